// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EXE and write-back.
//
// Accepts one instruction per handshake from the 110-bit EXE->MEM bus. It then
// performs any load/store through a request/ready data-memory port, doing
// byte-lane steering and load extension. The result goes out as a 70-bit
// write-back bundle under a valid/ready handshake.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   EXE_MEM_BUS   {through[15:0], alu_data[31:0], out_data[31:0], pc[29:0]}
//   exe_valid     EXE_MEM_BUS holds a valid instruction
//   exe_ready     stage can accept this cycle (combinational from state, wb_ready)
//   dm_req        data-memory request, held until dm_ready is sampled
//   dm_we         1 = store, 0 = load
//   dm_addr       word address (alu_data[31:2])
//   dm_be         byte enables
//   dm_wdata      lane-replicated store data
//   dm_rdata      load data, valid with dm_ready
//   dm_ready      completes the outstanding request
//   MEM_WB_BUS    {wb_en, wb_dest[4:0], wb_data[31:0], pc[29:0], exc[1:0]}
//   wb_valid      MEM_WB_BUS valid
//   wb_ready      write-back accepts
module mem_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [109:0] EXE_MEM_BUS,
    input  logic         exe_valid,
    output logic         exe_ready,
    output logic         dm_req,
    output logic         dm_we,
    output logic [29:0]  dm_addr,
    output logic [3:0]   dm_be,
    output logic [31:0]  dm_wdata,
    input  logic [31:0]  dm_rdata,
    input  logic         dm_ready,
    output logic [69:0]  MEM_WB_BUS,
    output logic         wb_valid,
    input  logic         wb_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t state_reg;

    // Incoming bus fields
    logic [15:0] in_thr;
    logic [31:0] in_alu;
    logic [31:0] in_out;
    logic [29:0] in_pc;
    logic        in_rd;
    logic        in_wr;
    logic [1:0]  in_size;
    logic        in_uns;
    logic        in_wben;
    logic [4:0]  in_dest;
    logic [1:0]  in_a;
    logic        in_is_mem;
    logic        in_misalign;
    logic        in_go_access;
    logic [1:0]  in_exc;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic [69:0] in_direct_bus;
    logic        unused_thr_bits;

    assign in_thr  = EXE_MEM_BUS[109:94];
    assign in_alu  = EXE_MEM_BUS[93:62];
    assign in_out  = EXE_MEM_BUS[61:30];
    assign in_pc   = EXE_MEM_BUS[29:0];
    assign in_rd   = in_thr[15];
    assign in_wr   = in_thr[14];
    assign in_size = in_thr[13:12];
    assign in_uns  = in_thr[11];
    assign in_wben = in_thr[10];
    assign in_dest = in_thr[9:5];
    assign in_a    = in_alu[1:0];
    assign unused_thr_bits = ^{in_thr[4:0], in_alu[31:2] == 30'd0};

    assign in_is_mem = in_rd | in_wr;

    // Size 11 behaves as a word, so any size with bit 1 set needs word alignment.
    assign in_misalign = ((in_size == 2'b01) && in_a[0]) ||
                         (in_size[1] && (in_a != 2'b00));

    assign in_go_access = in_is_mem & ~in_misalign;

    // Both mem_rd and mem_wr set counts as a store, including for the exception code.
    assign in_exc = (in_is_mem && in_misalign) ? (in_wr ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        in_be    = 4'b1111;
        in_wdata = in_out;
        case (in_size)
            2'b00: begin
                in_be    = 4'b0001 << in_a;
                in_wdata = {4{in_out[7:0]}};
            end
            2'b01: begin
                in_be    = in_a[1] ? 4'b1100 : 4'b0011;
                in_wdata = {2{in_out[15:0]}};
            end
            default: begin
                in_be    = 4'b1111;
                in_wdata = in_out;
            end
        endcase
    end

    // Result for ops that skip the memory: non-memory ops pass wb_en through,
    // misaligned memory ops (the only memory ops taking this path) force it low.
    assign in_direct_bus = {in_wben & ~in_is_mem, in_dest, in_out, in_pc, in_exc};

    // Context kept across the ACCESS state
    logic        is_load_reg;
    logic        uns_reg;
    logic [1:0]  size_reg;
    logic [1:0]  a_reg;
    logic        wben_reg;
    logic [4:0]  dest_reg;
    logic [31:0] out_reg;
    logic [29:0] pc_reg;

    // Load lane selection and extension
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    always_comb begin
        lane_half = a_reg[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (a_reg)
            2'd0:    lane_byte = dm_rdata[7:0];
            2'd1:    lane_byte = dm_rdata[15:8];
            2'd2:    lane_byte = dm_rdata[23:16];
            default: lane_byte = dm_rdata[31:24];
        endcase
        case (size_reg)
            2'b00:   load_ext = {{24{~uns_reg & lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = {{16{~uns_reg & lane_half[15]}}, lane_half};
            default: load_ext = dm_rdata;
        endcase
    end

    logic [69:0] access_bus;
    assign access_bus = is_load_reg ? {wben_reg, dest_reg, load_ext, pc_reg, 2'b00}
                                    : {1'b0, dest_reg, out_reg, pc_reg, 2'b00};

    assign exe_ready = (state_reg == IDLE) || ((state_reg == OUT) && wb_ready);

    logic accept;
    assign accept = exe_valid & exe_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= 30'd0;
            dm_be       <= 4'd0;
            dm_wdata    <= 32'd0;
            MEM_WB_BUS  <= 70'd0;
            wb_valid    <= 1'b0;
            is_load_reg <= 1'b0;
            uns_reg     <= 1'b0;
            size_reg    <= 2'b00;
            a_reg       <= 2'b00;
            wben_reg    <= 1'b0;
            dest_reg    <= 5'd0;
            out_reg     <= 32'd0;
            pc_reg      <= 30'd0;
        end else if (accept) begin
            // Shared by IDLE and OUT-with-wb_ready: take the new instruction.
            is_load_reg <= in_rd & ~in_wr;
            uns_reg     <= in_uns;
            size_reg    <= in_size;
            a_reg       <= in_a;
            wben_reg    <= in_wben;
            dest_reg    <= in_dest;
            out_reg     <= in_out;
            pc_reg      <= in_pc;
            if (in_go_access) begin
                state_reg <= ACCESS;
                dm_req    <= 1'b1;
                dm_we     <= in_wr;
                dm_addr   <= in_alu[31:2];
                dm_be     <= in_be;
                dm_wdata  <= in_wdata;
                wb_valid  <= 1'b0;
            end else begin
                state_reg  <= OUT;
                dm_req     <= 1'b0;
                wb_valid   <= 1'b1;
                MEM_WB_BUS <= in_direct_bus;
            end
        end else begin
            case (state_reg)
                ACCESS: begin
                    if (dm_ready) begin
                        state_reg  <= OUT;
                        dm_req     <= 1'b0;
                        wb_valid   <= 1'b1;
                        MEM_WB_BUS <= access_bus;
                    end
                end
                OUT: begin
                    // Without an accept here, wb_ready means exe_valid was low.
                    if (wb_ready) begin
                        state_reg <= IDLE;
                        wb_valid  <= 1'b0;
                    end
                end
                IDLE: begin
                    wb_valid <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    dm_req    <= 1'b0;
                    wb_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [109:0] EXE_MEM_BUS;
    logic         exe_valid;
    logic         exe_ready;
    logic         dm_req;
    logic         dm_we;
    logic [29:0]  dm_addr;
    logic [3:0]   dm_be;
    logic [31:0]  dm_wdata;
    logic [31:0]  dm_rdata;
    logic         dm_ready_r;
    logic         force_ready;
    logic         dm_ready;
    logic [69:0]  MEM_WB_BUS;
    logic         wb_valid;
    logic         wb_ready;

    assign dm_ready = dm_ready_r | force_ready;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .EXE_MEM_BUS (EXE_MEM_BUS),
        .exe_valid   (exe_valid),
        .exe_ready   (exe_ready),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_be       (dm_be),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_ready    (dm_ready),
        .MEM_WB_BUS  (MEM_WB_BUS),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready)
    );

    typedef struct {
        logic [15:0] thr;
        logic [31:0] alu;
        logic [31:0] outd;
        logic [29:0] pc;
        int          delay;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_we;
        logic [29:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [69:0] exp_bus;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];

    logic [69:0] exp_q[$];
    logic [69:0] mon_exp;
    int errors = 0;
    int checks = 0;

    // Memory responder settings
    int          mem_delay = 0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_en = 1'b1;

    function automatic logic [15:0] thr(input logic rd, input logic wr, input logic [1:0] size,
                                        input logic uns, input logic wben, input logic [4:0] dest);
        return {rd, wr, size, uns, wben, dest, 5'b10101};
    endfunction

    function automatic logic [69:0] mk_bus(input logic en, input logic [4:0] dest, input logic [31:0] data,
                                           input logic [29:0] pc, input logic [1:0] exc);
        return {en, dest, data, pc, exc};
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Data-memory model: answers dm_req after mem_delay idle cycles.
    initial begin
        int cnt;
        cnt = 0;
        dm_ready_r = 1'b0;
        dm_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            dm_ready_r = 1'b0;
            if (dm_req && !rst && mem_en) begin
                if (cnt >= mem_delay) begin
                    dm_ready_r = 1'b1;
                    dm_rdata = mem_rdata;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Scoreboard: compare every write-back handshake with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            $display("wb txn bus=%h", MEM_WB_BUS);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got %h expected none", MEM_WB_BUS);
            end else begin
                mon_exp = exp_q.pop_front();
                check("wb_bus", MEM_WB_BUS, mon_exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic run_vec(input int i);
        vec_t v;
        int n;
        v = vecs[i];
        mem_delay = v.delay;
        mem_rdata = v.rdata;
        @(posedge clk);
        #1;
        EXE_MEM_BUS = {v.thr, v.alu, v.outd, v.pc};
        exe_valid = 1'b1;
        exp_q.push_back(v.exp_bus);
        $display("vec %0d drive thr=%h alu=%h out=%h", i, v.thr, v.alu, v.outd);
        @(posedge clk);
        #1;
        exe_valid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_dm_req", i), dm_req, v.exp_req);
        if (v.exp_req) begin
            check($sformatf("v%0d_dm_we", i), dm_we, v.exp_we);
            check($sformatf("v%0d_dm_addr", i), dm_addr, v.exp_addr);
            check($sformatf("v%0d_dm_be", i), dm_be, v.exp_be);
            if (v.exp_we)
                check($sformatf("v%0d_dm_wdata", i), dm_wdata, v.exp_wdata);
        end
        n = 0;
        while (!wb_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL v%0d_wb_timeout: got no wb_valid expected wb_valid", i);
        end
        @(posedge clk);
    endtask

    initial begin
        logic [69:0] exp_a;
        logic [69:0] exp_b;

        vecs[0]  = '{thr(1,0,2'b00,0,1,5'd7),  32'h1003, 32'h0,        30'h1000, 2, 32'h80FFFF7F, 1'b1, 1'b0, 30'h400,  4'b1000, 32'h0,        mk_bus(1,5'd7, 32'hFFFFFF80,30'h1000,2'b00)};
        vecs[1]  = '{thr(1,0,2'b00,1,1,5'd7),  32'h1003, 32'h0,        30'h1001, 2, 32'h80FFFF7F, 1'b1, 1'b0, 30'h400,  4'b1000, 32'h0,        mk_bus(1,5'd7, 32'h00000080,30'h1001,2'b00)};
        vecs[2]  = '{thr(0,1,2'b01,0,1,5'd9),  32'h2002, 32'h1234ABCD, 30'h1002, 1, 32'h0,        1'b1, 1'b1, 30'h800,  4'b1100, 32'hABCDABCD, mk_bus(0,5'd9, 32'h1234ABCD,30'h1002,2'b00)};
        vecs[3]  = '{thr(1,0,2'b10,0,1,5'd2),  32'h2001, 32'h55,       30'h1003, 0, 32'h0,        1'b0, 1'b0, 30'h0,    4'b0,    32'h0,        mk_bus(0,5'd2, 32'h00000055,30'h1003,2'b01)};
        vecs[4]  = '{thr(0,1,2'b10,0,1,5'd2),  32'h2002, 32'h66,       30'h1004, 0, 32'h0,        1'b0, 1'b0, 30'h0,    4'b0,    32'h0,        mk_bus(0,5'd2, 32'h00000066,30'h1004,2'b10)};
        vecs[5]  = '{thr(1,0,2'b01,0,1,5'd12), 32'h3002, 32'h0,        30'h1005, 0, 32'h80017FFE, 1'b1, 1'b0, 30'hC00,  4'b1100, 32'h0,        mk_bus(1,5'd12,32'hFFFF8001,30'h1005,2'b00)};
        vecs[6]  = '{thr(0,1,2'b00,0,1,5'd13), 32'h4001, 32'hDEADBEA5, 30'h1006, 3, 32'h0,        1'b1, 1'b1, 30'h1000, 4'b0010, 32'hA5A5A5A5, mk_bus(0,5'd13,32'hDEADBEA5,30'h1006,2'b00)};
        vecs[7]  = '{thr(1,0,2'b11,0,1,5'd31), 32'h5004, 32'h0,        30'h1007, 1, 32'hCAFEF00D, 1'b1, 1'b0, 30'h1401, 4'b1111, 32'h0,        mk_bus(1,5'd31,32'hCAFEF00D,30'h1007,2'b00)};
        vecs[8]  = '{thr(1,0,2'b01,1,1,5'd6),  32'h6000, 32'h0,        30'h1008, 0, 32'h12349ABC, 1'b1, 1'b0, 30'h1800, 4'b0011, 32'h0,        mk_bus(1,5'd6, 32'h00009ABC,30'h1008,2'b00)};
        vecs[9]  = '{thr(0,0,2'b00,0,0,5'd3),  32'h0001, 32'h77,       30'h1009, 0, 32'h0,        1'b0, 1'b0, 30'h0,    4'b0,    32'h0,        mk_bus(0,5'd3, 32'h00000077,30'h1009,2'b00)};
        vecs[10] = '{thr(1,0,2'b01,0,1,5'd8),  32'h7001, 32'h88,       30'h100A, 0, 32'h0,        1'b0, 1'b0, 30'h0,    4'b0,    32'h0,        mk_bus(0,5'd8, 32'h00000088,30'h100A,2'b01)};
        vecs[11] = '{thr(1,1,2'b10,0,1,5'd1),  32'h8000, 32'h99,       30'h100B, 0, 32'h0,        1'b1, 1'b1, 30'h2000, 4'b1111, 32'h00000099, mk_bus(0,5'd1, 32'h00000099,30'h100B,2'b00)};
        vecs[12] = '{thr(1,0,2'b00,0,1,5'd20), 32'h9001, 32'h0,        30'h100C, 1, 32'h00007F00, 1'b1, 1'b0, 30'h2400, 4'b0010, 32'h0,        mk_bus(1,5'd20,32'h0000007F,30'h100C,2'b00)};

        rst = 1'b1;
        exe_valid = 1'b0;
        EXE_MEM_BUS = '0;
        wb_ready = 1'b1;
        force_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_exe_ready", exe_ready, 1'b1);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_dm_req", dm_req, 1'b0);
        check("rst_dm_we", dm_we, 1'b0);
        check("rst_dm_addr", dm_addr, 30'd0);
        check("rst_dm_be", dm_be, 4'd0);
        check("rst_dm_wdata", dm_wdata, 32'd0);
        check("rst_wb_bus", MEM_WB_BUS, 70'd0);

        // Three back-to-back ALU ops
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            EXE_MEM_BUS = {thr(0,0,2'b00,0,1,5'(3 + k)), 32'h0, 32'(8'h11 * (k + 1)), 30'(30'h80 + k)};
            exe_valid = 1'b1;
            exp_q.push_back(mk_bus(1, 5'(3 + k), 32'(8'h11 * (k + 1)), 30'(30'h80 + k), 2'b00));
            $display("alu op %0d drive", k);
            @(negedge clk);
            check("b2b_exe_ready", exe_ready, 1'b1);
            if (k > 0)
                check("b2b_wb_valid", wb_valid, 1'b1);
            @(posedge clk);
            #1;
        end
        exe_valid = 1'b0;
        @(negedge clk);
        check("b2b_wb_valid_last", wb_valid, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_idle_after", wb_valid, 1'b0);

        // Table of single instructions
        for (int i = 0; i < NVEC; i++)
            run_vec(i);

        // Backpressure with a waiting instruction
        exp_a = mk_bus(1, 5'd10, 32'h0000AAAA, 30'h200, 2'b00);
        exp_b = mk_bus(1, 5'd11, 32'h0000BBBB, 30'h201, 2'b00);
        @(posedge clk);
        #1;
        wb_ready = 1'b0;
        EXE_MEM_BUS = {thr(0,0,2'b00,0,1,5'd10), 32'h0, 32'h0000AAAA, 30'h200};
        exe_valid = 1'b1;
        exp_q.push_back(exp_a);
        @(posedge clk);
        #1;
        EXE_MEM_BUS = {thr(0,0,2'b00,0,1,5'd11), 32'h0, 32'h0000BBBB, 30'h201};
        exp_q.push_back(exp_b);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_exe_ready", exe_ready, 1'b0);
            check("bp_wb_valid", wb_valid, 1'b1);
            check("bp_bus_hold", MEM_WB_BUS, exp_a);
        end
        @(posedge clk);
        #1;
        wb_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", exe_ready, 1'b1);
        @(posedge clk);
        #1;
        exe_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", wb_valid, 1'b1);
        check("bp_next_bus", MEM_WB_BUS, exp_b);
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_after", wb_valid, 1'b0);

        // Reset in the middle of ACCESS, then a stray dm_ready
        @(posedge clk);
        #1;
        mem_en = 1'b0;
        EXE_MEM_BUS = {thr(1,0,2'b10,0,1,5'd4), 32'h100, 32'h0, 30'h300};
        exe_valid = 1'b1;
        @(posedge clk);
        #1;
        exe_valid = 1'b0;
        @(negedge clk);
        check("ra_req_before", dm_req, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("ra_req_async", dm_req, 1'b0);
        check("ra_exe_ready", exe_ready, 1'b1);
        check("ra_wb_valid", wb_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        force_ready = 1'b1;
        mem_rdata = 32'h12345678;
        @(posedge clk);
        #1;
        force_ready = 1'b0;
        @(negedge clk);
        check("ra_late_req", dm_req, 1'b0);
        check("ra_late_wb_valid", wb_valid, 1'b0);
        mem_en = 1'b1;

        repeat (3) @(posedge clk);
        check("queue_drained", 70'(exp_q.size()), 70'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
